// File: rtl/anc_pwm_output.sv
// Sample-to-PWM output stage for the ANC anti-noise path: quantise, buffer, play one sample per frame.
// Optional build macro ANC_PWM_DITHER_EN adds LFSR dither ahead of truncation.
module anc_pwm_output #(
  parameter int PWM_BITS   = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAIN_SHIFT = 0
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          ready_in,
  input  logic [15:0]                   signal_in,
  input  logic                          mute_in,
  input  logic                          clear_flags_in,
  output logic                          pwm_out,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
  output logic                          underflow_out,
  output logic                          overflow_out
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [PWM_BITS-1:0] MID     = {1'b1, {(PWM_BITS-1){1'b0}}};
  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;
  localparam logic [0:0] ST_PRIME = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;

  logic signed [31:0]   shifted;
  logic signed [15:0]   sat_s;
  logic signed [15:0]   q_s;
  logic [PWM_BITS-1:0]  code;

  logic [PWM_BITS-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [PWM_BITS-1:0]  pwm_cnt;
  logic [PWM_BITS-1:0]  cnt_next;
  logic [PWM_BITS-1:0]  duty;
  logic [PWM_BITS-1:0]  duty_next;
  logic [0:0]           state;
  logic [0:0]           state_next;
  logic                 boundary;
  logic                 full;
  logic                 pop;
  logic                 push_ok;
  logic                 uf_set;
  logic                 of_set;

  // 32-bit working width leaves headroom for any shift up to 7, so clamping sees the true value
  always_comb begin
    shifted = 32'(signed'(signal_in)) <<< GAIN_SHIFT;
    if (shifted > 32'sd32767)
      sat_s = 16'sh7FFF;
    else if (shifted < -32'sd32768)
      sat_s = -16'sh8000;
    else
      sat_s = shifted[15:0];
  end

`ifdef ANC_PWM_DITHER_EN
  localparam logic [15:0] DITH_MASK = 16'((32'd1 << (16 - PWM_BITS)) - 32'd1);
  logic [15:0]        lfsr;
  logic signed [16:0] dith_sum;

  // Dither only ever adds, so saturation is needed at the positive rail only
  always_comb begin
    dith_sum = $signed({sat_s[15], sat_s}) + $signed({1'b0, lfsr & DITH_MASK});
    q_s      = (dith_sum > 17'sd32767) ? 16'sh7FFF : dith_sum[15:0];
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      lfsr <= 16'hACE1;
    else if (push_ok)
      lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end
`else
  assign q_s = sat_s;
`endif

  // Flipping the MSB of the truncated two's-complement value gives offset binary
  assign code = PWM_BITS'(q_s >>> (16 - PWM_BITS)) ^ MID;

  always_comb begin
    boundary   = (pwm_cnt == CNT_MAX);
    full       = (count == CW'(FIFO_DEPTH));
    cnt_next   = pwm_cnt + PWM_BITS'(1);
    pop        = 1'b0;
    uf_set     = 1'b0;
    duty_next  = duty;
    state_next = state;
    if (boundary) begin
      if (state == ST_PRIME) begin
        duty_next = MID;
        if (count >= CW'(FIFO_DEPTH / 2))
          state_next = ST_RUN;
      end else if (count != '0) begin
        pop       = 1'b1;
        duty_next = mute_in ? MID : mem[rd_ptr];
      end else begin
        duty_next  = MID;
        uf_set     = 1'b1;
        state_next = ST_PRIME;
      end
    end
    push_ok = ready_in && (!full || pop);
    of_set  = ready_in && full && !pop;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pwm_cnt <= '0;
      duty    <= MID;
      state   <= ST_PRIME;
      pwm_out <= 1'b0;
    end else begin
      pwm_cnt <= cnt_next;
      duty    <= duty_next;
      state   <= state_next;
      pwm_out <= (cnt_next < duty_next);
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_ok)
      mem[wr_ptr] <= code;
  end

  // Pointers wrap for free because the depth is a power of two
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push_ok) - CW'(pop);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      underflow_out <= 1'b0;
      overflow_out  <= 1'b0;
    end else begin
      underflow_out <= uf_set | (underflow_out & ~clear_flags_in);
      overflow_out  <= of_set | (overflow_out & ~clear_flags_in);
    end
  end

  assign fifo_count_out = count;

endmodule
